// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter with registered one-hot grant.
// The current owner keeps the grant while its request stays high; when it
// drops, the next round-robin winner is granted on the same edge.
// Optional feature: define ARB_MAX_HOLD_EN to cap ownership at MAX_HOLD
// cycles when another port is waiting (forced rotation, preempt_o pulse).
module rr_hold_arbiter #(
  parameter  int NUM_PORTS = 4,
  parameter  int MAX_HOLD  = 8,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_valid_o,
  output logic [IDX_W-1:0]     gnt_idx_o,
  output logic                 preempt_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [NUM_PORTS-1:0] gnt_reg, gnt_next;
  logic                 valid_reg, valid_next;
  logic                 preempt_reg, preempt_next;

  // Arbitration decision shared between the next-state and output logic
  logic                 do_grant;
  logic                 do_preempt;
  logic [IDX_W-1:0]     win_idx;
  logic [NUM_PORTS-1:0] win_onehot;
  logic [NUM_PORTS-1:0] others_req;
  logic                 owner_req;
  logic                 hold_expired;
  logic [IDX_W-1:0]     owner_plus1;
  logic [IDX_W:0]       rr_res;
  logic [IDX_W:0]       pre_res;

  // Increment an index, wrapping from NUM_PORTS-1 back to 0
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (int'(v) >= NUM_PORTS - 1) begin
      return '0;
    end
    return v + IDX_W'(1);
  endfunction

  // First set bit of mask at or above start, wrapping; returns {found, index}
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] mask,
                                             input logic [IDX_W-1:0]     start);
    logic             found;
    logic [IDX_W-1:0] pick;
    int               pos;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos = int'(start) + i;
      if (pos >= NUM_PORTS) begin
        pos = pos - NUM_PORTS;
      end
      if (!found && mask[pos]) begin
        found = 1'b1;
        pick  = IDX_W'(pos);
      end
    end
    return {found, pick};
  endfunction

  // Per-port masks: competing requests and one-hot decode of the winner
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign others_req[gi] = req_i[gi] & ~gnt_reg[gi];
      assign win_onehot[gi] = (win_idx == IDX_W'(gi));
    end
  endgenerate

  assign owner_req   = req_i[idx_reg];
  assign owner_plus1 = wrap_inc(idx_reg);
  assign rr_res      = rr_pick(req_i, ptr_reg);
  assign pre_res     = rr_pick(others_req, owner_plus1);

`ifdef ARB_MAX_HOLD_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic [7:0] hold_cnt_reg, hold_cnt_next;

  assign hold_expired = (hold_cnt_reg == HOLD_LIM);

  // Hold counter: 1 on the grant edge, then counts up and saturates
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (do_grant) begin
      hold_cnt_next = 8'd1;
    end else if (state_next == ST_IDLE) begin
      hold_cnt_next = '0;
    end else if (hold_cnt_reg != HOLD_LIM) begin
      hold_cnt_next = hold_cnt_reg + 8'd1;
    end
  end

  // Hold counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt_reg <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end
`else
  // Unlimited hold: ownership is never forcibly rotated
  assign hold_expired = 1'b0;
`endif

  // Next-state logic: decide whether a (new) grant is issued this edge
  always_comb begin
    state_next = state_reg;
    do_grant   = 1'b0;
    do_preempt = 1'b0;
    win_idx    = idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rr_res[IDX_W]) begin
          state_next = ST_GRANT;
          do_grant   = 1'b1;
          win_idx    = rr_res[IDX_W-1:0];
        end
      end
      ST_GRANT: begin
        if (owner_req) begin
          // Owner still wants it; only a hold timeout with a waiter moves it
          if (hold_expired && pre_res[IDX_W]) begin
            do_grant   = 1'b1;
            do_preempt = 1'b1;
            win_idx    = pre_res[IDX_W-1:0];
          end
        end else if (rr_res[IDX_W]) begin
          // Owner released: hand over directly, no idle bubble
          do_grant = 1'b1;
          win_idx  = rr_res[IDX_W-1:0];
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered grant outputs and pointer
  always_comb begin
    gnt_next     = gnt_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    ptr_next     = ptr_reg;
    preempt_next = do_preempt;
    if (do_grant) begin
      gnt_next   = win_onehot;
      idx_next   = win_idx;
      valid_next = 1'b1;
      ptr_next   = wrap_inc(win_idx);
    end else if (state_next == ST_IDLE) begin
      gnt_next   = '0;
      idx_next   = '0;
      valid_next = 1'b0;
    end
  end

  // State register plus registered outputs, all updated on one edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      idx_reg     <= '0;
      gnt_reg     <= '0;
      valid_reg   <= 1'b0;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      gnt_reg     <= gnt_next;
      valid_reg   <= valid_next;
      preempt_reg <= preempt_next;
    end
  end

  assign gnt_o       = gnt_reg;
  assign gnt_valid_o = valid_reg;
  assign gnt_idx_o   = idx_reg;
  assign preempt_o   = preempt_reg;

endmodule
